imm_gen_stage: RTL



---
 rtl/imm_gen_stage.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/imm_gen_stage.sv
// Pipelined RV32I/RV64I immediate generator with a registered output stage and a 2-entry skid buffer.
// Optional branch/jump target output is enabled by defining IMMGEN_TARGET_EN.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic [TAG_W-1:0] out_tag,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal
`ifdef IMMGEN_TARGET_EN
    ,
    output logic [XLEN-1:0]  out_target
`endif
);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    typedef struct packed {
        logic [31:0]      instr;
        logic [XLEN-1:0]  pc;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illegal;
`ifdef IMMGEN_TARGET_EN
        logic [XLEN-1:0]  target;
`endif
    } entry_t;

    entry_t dec_entry;
    entry_t main_q, main_d, skid_q, skid_d;
    logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic   accept, drain;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] hi7;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign hi7    = in_instr[31:25];

    always_comb begin
        dec_entry       = '0;
        dec_entry.instr = in_instr;
        dec_entry.pc    = in_pc;
        dec_entry.tag   = in_tag;
        case (opcode)
            7'b0110111, 7'b0010111: begin
                dec_entry.fmt = FMT_U;
                dec_entry.imm = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
            end
            7'b1101111: begin
                dec_entry.fmt = FMT_J;
                dec_entry.imm = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0};
            end
            7'b1100011: begin
                dec_entry.fmt = FMT_B;
                dec_entry.imm = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0};
            end
            7'b0100011: begin
                dec_entry.fmt = FMT_S;
                dec_entry.imm = {{(XLEN-11){in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
            end
            7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
                dec_entry.fmt = FMT_I;
                dec_entry.imm = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
            end
            7'b0010011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_entry.fmt = FMT_SHAMT;
                    // RV64 widens the shift amount by one bit, shrinking the must-be-zero field
                    if (XLEN == 64) begin
                        dec_entry.imm     = XLEN'(in_instr[25:20]);
                        dec_entry.illegal = !((hi7[6:1] == 6'b0) ||
                                              (funct3 == 3'b101 && hi7[6:1] == 6'b010000));
                    end else begin
                        dec_entry.imm     = XLEN'(in_instr[24:20]);
                        dec_entry.illegal = !((hi7 == 7'b0) ||
                                              (funct3 == 3'b101 && hi7 == 7'b0100000));
                    end
                end else begin
                    dec_entry.fmt = FMT_I;
                    dec_entry.imm = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
                end
            end
            7'b0011011: begin
                if (XLEN != 64) begin
                    dec_entry.illegal = 1'b1;
                end else if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_entry.fmt     = FMT_SHAMT;
                    dec_entry.imm     = XLEN'(in_instr[24:20]);
                    dec_entry.illegal = !((hi7 == 7'b0) ||
                                          (funct3 == 3'b101 && hi7 == 7'b0100000));
                end else begin
                    dec_entry.fmt = FMT_I;
                    dec_entry.imm = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
                end
            end
            7'b0110011: dec_entry.fmt = FMT_NONE;
            7'b0111011: dec_entry.illegal = (XLEN != 64);
            default:    dec_entry.illegal = 1'b1;
        endcase
`ifdef IMMGEN_TARGET_EN
        if (dec_entry.fmt == FMT_B || dec_entry.fmt == FMT_J || opcode == 7'b0010111) begin
            dec_entry.target = in_pc + dec_entry.imm;
        end
`endif
    end

    // Inputs are only accepted while the skid slot is free, so skid->main never races an input
    assign accept = in_valid && !skid_valid_q && !flush;
    assign drain  = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_d = dec_entry;
                end
            end
        end else if (accept) begin
            skid_d       = dec_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready    = !skid_valid_q;
    assign out_valid   = main_valid_q;
    assign out_instr   = main_q.instr;
    assign out_pc      = main_q.pc;
    assign out_tag     = main_q.tag;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
`ifdef IMMGEN_TARGET_EN
    assign out_target  = main_q.target;
`endif

endmodule
